screen_sequencer: RTL

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_pkg.sv | 46 ++++
 rtl/screen_sequencer_if.sv | 28 ++
 rtl/sync2.sv | 24 ++
 rtl/screen_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared types and constants for the screen sequencer.
//   state_e         : mode FSM states (static / auto / step)
//   rgb_t           : 30-bit RGB triple, 10 bits per channel
//   palette_entry_t : foreground + background triple for one screen
//   PALETTE         : per-screen colours, indexed by SCREEN_IDX
//   STATIC_ENTRY    : fixed colours shown while sequencing is disabled
package screen_pkg;

    typedef enum logic [1:0] {
        StStatic,
        StAuto,
        StStep
    } state_e;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t fg;
        rgb_t bg;
    } palette_entry_t;

    localparam palette_entry_t PALETTE [4] = '{
        '{fg: '{r: 10'd1000, g: 10'd0,    b: 10'd0},
          bg: '{r: 10'd0,    g: 10'd0,    b: 10'd0}},
        '{fg: '{r: 10'd1000, g: 10'd1000, b: 10'd1000},
          bg: '{r: 10'd0,    g: 10'd0,    b: 10'd1000}},
        '{fg: '{r: 10'd1000, g: 10'd0,    b: 10'd750},
          bg: '{r: 10'd1000, g: 10'd750,  b: 10'd0}},
        '{fg: '{r: 10'd0,    g: 10'd1000, b: 10'd0},
          bg: '{r: 10'd0,    g: 10'd0,    b: 10'd0}}
    };

    localparam palette_entry_t STATIC_ENTRY = PALETTE[2];

    function automatic palette_entry_t swap_entry(palette_entry_t e);
        palette_entry_t s;
        s.fg = e.bg;
        s.bg = e.fg;
        return s;
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle of the sequencer's switch/button/tick inputs and colour outputs.
//   slave  : the sequencer side (switches and tick in, colours out)
//   master : the driving side (switches and tick out, colours in)
interface screen_sequencer_if;
    logic       SW15;
    logic       SW16;
    logic       SW17;
    logic       KEY0;
    logic       FRAME_TICK;
    logic [9:0] RO;
    logic [9:0] GO;
    logic [9:0] BO;
    logic [9:0] RO1;
    logic [9:0] GO1;
    logic [9:0] BO1;
    logic [1:0] SCREEN_IDX;
    logic       COLOR_VALID;

    modport slave (
        input  SW15, SW16, SW17, KEY0, FRAME_TICK,
        output RO, GO, BO, RO1, GO1, BO1, SCREEN_IDX, COLOR_VALID
    );

    modport master (
        output SW15, SW16, SW17, KEY0, FRAME_TICK,
        input  RO, GO, BO, RO1, GO1, BO1, SCREEN_IDX, COLOR_VALID
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output; both flops reset to RESET_VAL
module sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/screen_sequencer.sv
// Cycles a 4-entry colour palette across screens, advancing automatically every
// DWELL_FRAMES frames or on a button press, with fg/bg swap and a fixed static palette.
//   CLOCK_50, RESET : clock and synchronous active-high reset
//   bus (slave)     : SW15/SW16/SW17/KEY0 async controls, FRAME_TICK, registered
//                     fg (RO/GO/BO) and bg (RO1/GO1/BO1) colours, SCREEN_IDX, COLOR_VALID
import screen_pkg::*;

module screen_sequencer #(
    parameter int unsigned DWELL_FRAMES = 60
) (
    input logic               CLOCK_50,
    input logic               RESET,
    screen_sequencer_if.slave bus
);
    localparam logic [9:0] LAST_FRAME = 10'(DWELL_FRAMES - 1);

    logic           sw15_s, sw16_s, sw17_s, key_s;
    logic           key_prev_q, key_fall;
    state_e         state_q, state_d;
    logic [9:0]     cnt_q, cnt_d;
    logic           pend_q, pend_d;
    logic [1:0]     idx_q, idx_d;
    palette_entry_t colour_q, colour_d;
    logic           valid_q;

    sync2 #(.RESET_VAL(1'b0)) u_sync_sw15 (.clk(CLOCK_50), .rst(RESET), .d(bus.SW15), .q(sw15_s));
    sync2 #(.RESET_VAL(1'b0)) u_sync_sw16 (.clk(CLOCK_50), .rst(RESET), .d(bus.SW16), .q(sw16_s));
    sync2 #(.RESET_VAL(1'b0)) u_sync_sw17 (.clk(CLOCK_50), .rst(RESET), .d(bus.SW17), .q(sw17_s));
    sync2 #(.RESET_VAL(1'b1)) u_sync_key0 (.clk(CLOCK_50), .rst(RESET), .d(bus.KEY0), .q(key_s));

    // KEY0 is active-low, so a press is a 1 -> 0 transition.
    assign key_fall = key_prev_q & ~key_s;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= StStatic;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode only changes on a frame tick.
    always_comb begin
        state_d = state_q;
        if (bus.FRAME_TICK) begin
            if (!sw15_s) begin
                state_d = StStatic;
            end else if (sw16_s) begin
                state_d = StAuto;
            end else begin
                state_d = StStep;
            end
        end
    end

    // Counter/index act on the mode held up to this tick; colours show the mode after it.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        pend_d = pend_q | key_fall;
        if (bus.FRAME_TICK) begin
            pend_d = 1'b0;
            cnt_d  = '0;
            case (state_q)
                StAuto: begin
                    if (cnt_q != LAST_FRAME) begin
                        cnt_d = cnt_q + 10'd1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                StStep: begin
                    // A press detected on the tick itself counts for this tick.
                    if (pend_q || key_fall) begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end

        if (state_d == StStatic) begin
            colour_d = STATIC_ENTRY;
        end else if (sw17_s) begin
            colour_d = swap_entry(PALETTE[idx_d]);
        end else begin
            colour_d = PALETTE[idx_d];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            key_prev_q <= 1'b1;
            colour_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            key_prev_q <= key_s;
            if (bus.FRAME_TICK) begin
                colour_q <= colour_d;
                valid_q  <= 1'b1;
            end
        end
    end

    assign bus.RO          = colour_q.fg.r;
    assign bus.GO          = colour_q.fg.g;
    assign bus.BO          = colour_q.fg.b;
    assign bus.RO1         = colour_q.bg.r;
    assign bus.GO1         = colour_q.bg.g;
    assign bus.BO1         = colour_q.bg.b;
    assign bus.SCREEN_IDX  = idx_q;
    assign bus.COLOR_VALID = valid_q;
endmodule
